// File: rtl/rdma_rx_pkg.sv
// Shared constants for the RDMA receive header filter: reject codes,
// protocol identifiers, minimum header sizes and the checksum fold helper.
package rdma_rx_pkg;

  typedef enum logic [3:0] {
    ERR_NONE  = 4'd0,
    ERR_MAC   = 4'd1,
    ERR_ETYPE = 4'd2,
    ERR_VER   = 4'd3,
    ERR_IHL   = 4'd4,
    ERR_CKSUM = 4'd5,
    ERR_PROTO = 4'd6,
    ERR_PORT  = 4'd7,
    ERR_LEN   = 4'd8,
    ERR_FRAME = 4'd9
  } err_code_e;

  localparam logic [15:0] ETHERTYPE_IPV4   = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP     = 8'h11;
  localparam logic [3:0]  IP_VERSION_4     = 4'd4;
  localparam logic [3:0]  IP_IHL_MIN       = 4'd5;
  localparam logic [15:0] IP_HDR_LEN       = 16'd20;
  localparam logic [15:0] UDP_HDR_LEN      = 16'd8;
  localparam logic [15:0] IP_TOTAL_LEN_MIN = 16'd28;
  localparam logic [47:0] MAC_BCAST        = 48'hFFFF_FFFF_FFFF;

  // One's-complement fold of the 32-bit partial sum; a correct header sums to 0xFFFF.
  function automatic logic cksum_ok(input logic [31:0] accum);
    logic [16:0] fold1;
    logic [15:0] fin;
    fold1 = {1'b0, accum[15:0]} + {1'b0, accum[31:16]};
    fin   = fold1[15:0] + {15'd0, fold1[16]};
    return (fin == 16'hFFFF);
  endfunction

endpackage

// File: rtl/rdma_sync_fifo.sv
// Single-clock first-word-fall-through queue with occupancy output.
// Read data is forced to zero while empty so the consumer never sees stale words.
module rdma_sync_fifo
  import rdma_rx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic [AW:0]      level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      level_q;
  logic [AW:0]      level_d;
  logic             full;
  logic             wr_en;
  logic             rd_en;

  assign full    = (level_q == (AW+1)'(DEPTH));
  assign valid_o = (level_q != '0);
  assign wr_en   = push_i && !full;
  assign rd_en   = pop_i && valid_o;
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign level_o = level_q;

  // Storage array: data only, never reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= data_i;
  end

  // Occupancy next state; simultaneous push and pop leaves it unchanged.
  always_comb begin
    level_d = level_q;
    if (wr_en && !rd_en)      level_d = level_q + 1'b1;
    else if (rd_en && !wr_en) level_d = level_q - 1'b1;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/rdma_rx_hdr_filter.sv
// Receive-side header filter for RDMA over UDP/IPv4. Stage 1 captures the
// extracted header fields; stage 2 runs all checks, queues passing headers
// into the output FIFO and reports rejections with a prioritised code.
module rdma_rx_hdr_filter
  import rdma_rx_pkg::*;
#(
  parameter logic [47:0]             LOCAL_MAC    = 48'h000A35010203,
  parameter int                      NUM_PORTS    = 4,
  // Index 0 sits in the LSBs: 5005 is index 0, 5008 is index 3.
  parameter logic [NUM_PORTS*16-1:0] PORT_LIST    = {16'd5008, 16'd5007, 16'd5006, 16'd5005},
  parameter bit                      ACCEPT_BCAST = 1'b1,
  parameter bit                      CHECK_CKSUM  = 1'b1,
  parameter int                      FIFO_DEPTH   = 8,
  parameter int                      CNT_W        = 32,
  localparam int                     PIW          = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  localparam int                     LW           = $clog2(FIFO_DEPTH) + 1
)(
  input  logic             clk,
  input  logic             rst,
  input  logic [47:0]      s_dst_mac,
  input  logic [15:0]      s_ethertype,
  input  logic [3:0]       s_ip_version,
  input  logic [3:0]       s_ip_ihl,
  input  logic [7:0]       s_ip_protocol,
  input  logic [15:0]      s_ip_total_len,
  input  logic [31:0]      s_checksum_accum,
  input  logic [31:0]      s_src_ip,
  input  logic [31:0]      s_dst_ip,
  input  logic [15:0]      s_src_port,
  input  logic [15:0]      s_dst_port,
  input  logic [15:0]      s_udp_len,
  input  logic             s_frame_err,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [31:0]      m_src_ip,
  output logic [31:0]      m_dst_ip,
  output logic [15:0]      m_src_port,
  output logic [15:0]      m_dst_port,
  output logic [15:0]      m_payload_len,
  output logic [PIW-1:0]   m_port_idx,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             err_valid,
  output logic [3:0]       err_code,
  output logic [CNT_W-1:0] stat_ok,
  output logic [CNT_W-1:0] stat_drop,
  input  logic             stat_clr,
  output logic [LW-1:0]    fifo_level
);

  localparam int OUT_W = 32 + 32 + 16 + 16 + 16 + PIW;

  // Saturating increment for the statistics counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic             s_fire;
  logic             vld_p1_q;
  logic [47:0]      dst_mac_p1_q;
  logic [15:0]      etype_p1_q;
  logic [3:0]       ver_p1_q;
  logic [3:0]       ihl_p1_q;
  logic [7:0]       proto_p1_q;
  logic [15:0]      tot_len_p1_q;
  logic [31:0]      accum_p1_q;
  logic [31:0]      src_ip_p1_q;
  logic [31:0]      dst_ip_p1_q;
  logic [15:0]      src_port_p1_q;
  logic [15:0]      dst_port_p1_q;
  logic [15:0]      udp_len_p1_q;
  logic             frame_err_p1_q;

  logic             mac_ok_p1;
  logic             cksum_good_p1;
  logic             len_ok_p1;
  logic             port_hit_p1;
  logic [PIW-1:0]   port_idx_p1;
  err_code_e        code_p1;
  logic             push_p1;
  logic             rej_p1;
  logic [OUT_W-1:0] out_word_p1;

  logic             err_valid_q;
  logic [3:0]       err_code_q;
  logic [CNT_W-1:0] stat_ok_q;
  logic [CNT_W-1:0] stat_ok_d;
  logic [CNT_W-1:0] stat_drop_q;
  logic [CNT_W-1:0] stat_drop_d;

  logic [OUT_W-1:0] fifo_rd_data;
  logic [LW-1:0]    fifo_level_w;

  // Admit a header only when a FIFO slot remains after the stage-1 header lands.
  assign s_ready = !rst &&
                   ((LW'(FIFO_DEPTH) - fifo_level_w) > {{(LW-1){1'b0}}, vld_p1_q});
  assign s_fire  = s_valid && s_ready;

  // ---- stage 1: capture accepted header fields ----

  // Stage-1 occupancy flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_p1_q <= 1'b0;
    else     vld_p1_q <= s_fire;
  end

  // Stage-1 header fields, loaded on every accepted transfer.
  always_ff @(posedge clk) begin
    if (s_fire) begin
      dst_mac_p1_q   <= s_dst_mac;
      etype_p1_q     <= s_ethertype;
      ver_p1_q       <= s_ip_version;
      ihl_p1_q       <= s_ip_ihl;
      proto_p1_q     <= s_ip_protocol;
      tot_len_p1_q   <= s_ip_total_len;
      accum_p1_q     <= s_checksum_accum;
      src_ip_p1_q    <= s_src_ip;
      dst_ip_p1_q    <= s_dst_ip;
      src_port_p1_q  <= s_src_port;
      dst_port_p1_q  <= s_dst_port;
      udp_len_p1_q   <= s_udp_len;
      frame_err_p1_q <= s_frame_err;
    end
  end

  // ---- stage 2: evaluate checks, enqueue or reject ----

  assign mac_ok_p1     = (dst_mac_p1_q == LOCAL_MAC) ||
                         (ACCEPT_BCAST && (dst_mac_p1_q == MAC_BCAST));
  assign cksum_good_p1 = !CHECK_CKSUM || cksum_ok(accum_p1_q);
  assign len_ok_p1     = (tot_len_p1_q >= IP_TOTAL_LEN_MIN) &&
                         (udp_len_p1_q >= UDP_HDR_LEN) &&
                         (udp_len_p1_q == tot_len_p1_q - IP_HDR_LEN);

  // Port lookup; scanning downward leaves the lowest matching index.
  always_comb begin
    port_hit_p1 = 1'b0;
    port_idx_p1 = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (dst_port_p1_q == PORT_LIST[i*16 +: 16]) begin
        port_hit_p1 = 1'b1;
        port_idx_p1 = PIW'(i);
      end
    end
  end

  // Reject code, highest-priority failure wins.
  always_comb begin
    code_p1 = ERR_NONE;
    if (frame_err_p1_q)                     code_p1 = ERR_FRAME;
    else if (!mac_ok_p1)                    code_p1 = ERR_MAC;
    else if (etype_p1_q != ETHERTYPE_IPV4)  code_p1 = ERR_ETYPE;
    else if (ver_p1_q != IP_VERSION_4)      code_p1 = ERR_VER;
    else if (ihl_p1_q != IP_IHL_MIN)        code_p1 = ERR_IHL;
    else if (!cksum_good_p1)                code_p1 = ERR_CKSUM;
    else if (proto_p1_q != IP_PROTO_UDP)    code_p1 = ERR_PROTO;
    else if (!port_hit_p1)                  code_p1 = ERR_PORT;
    else if (!len_ok_p1)                    code_p1 = ERR_LEN;
  end

  assign push_p1     = vld_p1_q && (code_p1 == ERR_NONE);
  assign rej_p1      = vld_p1_q && (code_p1 != ERR_NONE);
  assign out_word_p1 = {src_ip_p1_q, dst_ip_p1_q, src_port_p1_q, dst_port_p1_q,
                        udp_len_p1_q - UDP_HDR_LEN, port_idx_p1};

  // Counter next state; a clear overrides any same-cycle event.
  always_comb begin
    stat_ok_d   = stat_ok_q;
    stat_drop_d = stat_drop_q;
    if (stat_clr) begin
      stat_ok_d   = '0;
      stat_drop_d = '0;
    end else begin
      if (push_p1) stat_ok_d   = sat_inc(stat_ok_q);
      if (rej_p1)  stat_drop_d = sat_inc(stat_drop_q);
    end
  end

  // Rejection reporting and statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_valid_q <= 1'b0;
      err_code_q  <= 4'd0;
      stat_ok_q   <= '0;
      stat_drop_q <= '0;
    end else begin
      err_valid_q <= rej_p1;
      if (rej_p1) err_code_q <= code_p1;
      stat_ok_q   <= stat_ok_d;
      stat_drop_q <= stat_drop_d;
    end
  end

  rdma_sync_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_p1),
    .data_i  (out_word_p1),
    .pop_i   (m_ready),
    .data_o  (fifo_rd_data),
    .valid_o (m_valid),
    .level_o (fifo_level_w)
  );

  assign {m_src_ip, m_dst_ip, m_src_port, m_dst_port, m_payload_len, m_port_idx} = fifo_rd_data;
  assign fifo_level = fifo_level_w;
  assign err_valid  = err_valid_q;
  assign err_code   = err_code_q;
  assign stat_ok    = stat_ok_q;
  assign stat_drop  = stat_drop_q;

endmodule

// File: tb/tb_rdma_rx_hdr_filter.sv
// Scoreboard bench for rdma_rx_hdr_filter. A second instance with the
// checksum check disabled and 2-bit counters shares the stimulus.
`timescale 1ns/1ps
module tb_rdma_rx_hdr_filter;

  typedef struct packed {
    logic [47:0] dst_mac;
    logic [15:0] etype;
    logic [3:0]  ver;
    logic [3:0]  ihl;
    logic [7:0]  proto;
    logic [15:0] tot_len;
    logic [31:0] accum;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] udp_len;
    logic        frame_err;
  } hdr_t;

  typedef struct packed {
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] plen;
    logic [1:0]  idx;
  } out_t;

  logic        clk = 1'b0;
  logic        rst;
  hdr_t        hin;
  logic        s_valid, s_ready, s_valid2, s_ready2;
  logic [31:0] m_src_ip, m_dst_ip, m_src_ip2, m_dst_ip2;
  logic [15:0] m_src_port, m_dst_port, m_payload_len, m_src_port2, m_dst_port2, m_payload_len2;
  logic [1:0]  m_port_idx, m_port_idx2;
  logic        m_valid, m_ready, m_valid2;
  logic        err_valid, err_valid2;
  logic [3:0]  err_code, err_code2;
  logic [31:0] stat_ok, stat_drop;
  logic [1:0]  stat_ok2, stat_drop2;
  logic        stat_clr;
  logic [3:0]  fifo_level, fifo_level2;

  always #5 clk = ~clk;

  assign s_valid2 = s_valid && s_ready;

  rdma_rx_hdr_filter u_dut (
    .clk(clk), .rst(rst),
    .s_dst_mac(hin.dst_mac), .s_ethertype(hin.etype), .s_ip_version(hin.ver),
    .s_ip_ihl(hin.ihl), .s_ip_protocol(hin.proto), .s_ip_total_len(hin.tot_len),
    .s_checksum_accum(hin.accum), .s_src_ip(hin.src_ip), .s_dst_ip(hin.dst_ip),
    .s_src_port(hin.src_port), .s_dst_port(hin.dst_port), .s_udp_len(hin.udp_len),
    .s_frame_err(hin.frame_err), .s_valid(s_valid), .s_ready(s_ready),
    .m_src_ip(m_src_ip), .m_dst_ip(m_dst_ip), .m_src_port(m_src_port),
    .m_dst_port(m_dst_port), .m_payload_len(m_payload_len), .m_port_idx(m_port_idx),
    .m_valid(m_valid), .m_ready(m_ready), .err_valid(err_valid), .err_code(err_code),
    .stat_ok(stat_ok), .stat_drop(stat_drop), .stat_clr(stat_clr), .fifo_level(fifo_level)
  );

  rdma_rx_hdr_filter #(.CHECK_CKSUM(1'b0), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .s_dst_mac(hin.dst_mac), .s_ethertype(hin.etype), .s_ip_version(hin.ver),
    .s_ip_ihl(hin.ihl), .s_ip_protocol(hin.proto), .s_ip_total_len(hin.tot_len),
    .s_checksum_accum(hin.accum), .s_src_ip(hin.src_ip), .s_dst_ip(hin.dst_ip),
    .s_src_port(hin.src_port), .s_dst_port(hin.dst_port), .s_udp_len(hin.udp_len),
    .s_frame_err(hin.frame_err), .s_valid(s_valid2), .s_ready(s_ready2),
    .m_src_ip(m_src_ip2), .m_dst_ip(m_dst_ip2), .m_src_port(m_src_port2),
    .m_dst_port(m_dst_port2), .m_payload_len(m_payload_len2), .m_port_idx(m_port_idx2),
    .m_valid(m_valid2), .m_ready(1'b1), .err_valid(err_valid2), .err_code(err_code2),
    .stat_ok(stat_ok2), .stat_drop(stat_drop2), .stat_clr(stat_clr), .fifo_level(fifo_level2)
  );

  int          n_chk = 0;
  int          n_err = 0;
  int          n_acc = 0;
  out_t        sb_q[$];
  logic [3:0]  err_q[$];
  logic [31:0] exp_ok1, exp_drop1;
  logic [1:0]  exp_ok2, exp_drop2;
  logic [3:0]  last_rej;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_code(input hdr_t h, input bit ck);
    logic [16:0] f;
    logic [15:0] s;
    f = {1'b0, h.accum[15:0]} + {1'b0, h.accum[31:16]};
    s = f[15:0] + {15'd0, f[16]};
    if (h.frame_err) return 4'd9;
    if (!(h.dst_mac == 48'h000A35010203 || h.dst_mac == 48'hFFFFFFFFFFFF)) return 4'd1;
    if (h.etype != 16'h0800) return 4'd2;
    if (h.ver != 4'd4) return 4'd3;
    if (h.ihl != 4'd5) return 4'd4;
    if (ck && s != 16'hFFFF) return 4'd5;
    if (h.proto != 8'h11) return 4'd6;
    if (h.dst_port < 16'd5005 || h.dst_port > 16'd5008) return 4'd7;
    if (h.tot_len < 16'd28 || h.udp_len < 16'd8 || h.udp_len != h.tot_len - 16'd20) return 4'd8;
    return 4'd0;
  endfunction

  function automatic hdr_t good_hdr(input logic [15:0] port, input logic [15:0] ulen);
    hdr_t h;
    h.dst_mac   = 48'h000A35010203;
    h.etype     = 16'h0800;
    h.ver       = 4'd4;
    h.ihl       = 4'd5;
    h.proto     = 8'h11;
    h.tot_len   = ulen + 16'd20;
    h.accum     = 32'h0000FFFF;
    h.src_ip    = $urandom;
    h.dst_ip    = $urandom;
    h.src_port  = 16'($urandom);
    h.dst_port  = port;
    h.udp_len   = ulen;
    h.frame_err = 1'b0;
    return h;
  endfunction

  // Record the expected outcome of an accepted header for both instances.
  task automatic expect_push(input hdr_t h);
    logic [3:0] c1, c2;
    out_t o;
    c1 = model_code(h, 1'b1);
    c2 = model_code(h, 1'b0);
    n_acc++;
    if (c1 == 4'd0) begin
      o = '{src_ip: h.src_ip, dst_ip: h.dst_ip, src_port: h.src_port, dst_port: h.dst_port,
            plen: h.udp_len - 16'd8, idx: 2'(h.dst_port - 16'd5005)};
      sb_q.push_back(o);
      if (exp_ok1 != 32'hFFFFFFFF) exp_ok1++;
    end else begin
      err_q.push_back(c1);
      last_rej = c1;
      if (exp_drop1 != 32'hFFFFFFFF) exp_drop1++;
    end
    if (c2 == 4'd0) begin
      if (exp_ok2 != 2'd3) exp_ok2++;
    end else begin
      if (exp_drop2 != 2'd3) exp_drop2++;
    end
  endtask

  // Called #1 after a posedge; returns #1 after the edge that took the header.
  task automatic send(input hdr_t h);
    int w;
    hin = h;
    s_valid = 1'b1;
    w = 0;
    while (!s_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (!s_ready) begin
      check("send_ready_timeout", 128'(s_ready), 128'(1));
      s_valid = 1'b0;
    end else begin
      expect_push(h);
      @(posedge clk);
      #1;
      s_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while ((sb_q.size() != 0 || err_q.size() != 0) && w < 300) begin
      @(posedge clk);
      w++;
    end
    if (sb_q.size() != 0 || err_q.size() != 0)
      check("idle_timeout", 128'(sb_q.size() + err_q.size()), 128'(0));
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic lat_test(input hdr_t h, input string tag);
    send(h);
    @(negedge clk);
    check({tag, "_mvalid_c1"}, 128'(m_valid), 128'(0));
    @(negedge clk);
    check({tag, "_mvalid_c2"}, 128'(m_valid), 128'(1));
    check({tag, "_port_idx"}, 128'(m_port_idx), 128'(2'(h.dst_port - 16'd5005)));
    check({tag, "_plen"}, 128'(m_payload_len), 128'(h.udp_len - 16'd8));
    check({tag, "_stat_ok"}, 128'(stat_ok), 128'(exp_ok1));
    @(posedge clk);
    #1;
  endtask

  // Output and rejection monitor; a held word is compared every cycle it waits.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_valid) begin
        if (sb_q.size() == 0) check("unexpected_output", 128'(1), 128'(0));
        else begin
          check("out_word",
                128'({m_src_ip, m_dst_ip, m_src_port, m_dst_port, m_payload_len, m_port_idx}),
                128'(sb_q[0]));
          if (m_ready) void'(sb_q.pop_front());
        end
      end
      if (err_valid) begin
        if (err_q.size() == 0) check("unexpected_err", 128'(err_code), 128'(0));
        else check("err_code", 128'(err_code), 128'(err_q.pop_front()));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    hdr_t h;
    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b1; stat_clr = 1'b0; hin = '0;
    exp_ok1 = '0; exp_drop1 = '0; exp_ok2 = '0; exp_drop2 = '0; last_rej = '0;
    #1;
    check("rst_s_ready", 128'(s_ready), 128'(0));
    check("rst_m_valid", 128'(m_valid), 128'(0));
    check("rst_err_valid", 128'(err_valid), 128'(0));
    check("rst_err_code", 128'(err_code), 128'(0));
    check("rst_stat_ok", 128'(stat_ok), 128'(0));
    check("rst_stat_drop", 128'(stat_drop), 128'(0));
    check("rst_fifo_level", 128'(fifo_level), 128'(0));
    check("rst_m_data", 128'({m_src_ip, m_dst_ip, m_payload_len}), 128'(0));
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1 check("release_s_ready", 128'(s_ready), 128'(1));

    // Basic latency: port 5006 -> index 1, payload 92.
    lat_test(good_hdr(16'd5006, 16'd100), "lat");

    // Single faults, combined fault and boundary cases.
    h = good_hdr(16'd5005, 16'd60); h.frame_err = 1'b1;          send(h);
    h = good_hdr(16'd5005, 16'd60); h.dst_mac = 48'h000A35010204; send(h);
    h = good_hdr(16'd5005, 16'd60); h.etype = 16'h86DD;          send(h);
    h = good_hdr(16'd5005, 16'd60); h.ver = 4'd6;                send(h);
    h = good_hdr(16'd5005, 16'd60); h.ihl = 4'd6;                send(h);
    h = good_hdr(16'd5005, 16'd60); h.accum = 32'h00010000;      send(h);
    h = good_hdr(16'd5005, 16'd60); h.proto = 8'h06;             send(h);
    h = good_hdr(16'd1234, 16'd60);                              send(h);
    h = good_hdr(16'd5005, 16'd60); h.udp_len = 16'd59;          send(h);
    h = good_hdr(16'd5005, 16'd7);                               send(h);
    h = good_hdr(16'd5005, 16'd60); h.dst_mac = 48'h1; h.accum = 32'h00010000; send(h);
    h = good_hdr(16'd5007, 16'd60); h.dst_mac = 48'hFFFFFFFFFFFF; send(h);
    h = good_hdr(16'd5005, 16'd60); h.accum = 32'h0001FFFE;      send(h);
    h = good_hdr(16'd5008, 16'd8);                               send(h);
    wait_idle();
    check("fault_stat_ok", 128'(stat_ok), 128'(exp_ok1));
    check("fault_stat_drop", 128'(stat_drop), 128'(exp_drop1));
    check("err_code_hold", 128'(err_code), 128'(last_rej));
    check("nock_stat_ok2", 128'(stat_ok2), 128'(exp_ok2));
    check("nock_stat_drop2", 128'(stat_drop2), 128'(exp_drop2));

    // Backpressure: accepts stop at the queue depth, then in-order drain.
    m_ready = 1'b0;
    n_acc = 0;
    fork
      begin
        for (int i = 0; i < 10; i++) send(good_hdr(16'(5005 + (i % 4)), 16'(40 + i)));
      end
      begin
        repeat (20) @(posedge clk);
        #2;
        check("bp_accepts", 128'(n_acc), 128'(8));
        check("bp_level", 128'(fifo_level), 128'(8));
        check("bp_s_ready", 128'(s_ready), 128'(0));
        m_ready = 1'b1;
      end
    join
    wait_idle();
    check("bp_stat_ok", 128'(stat_ok), 128'(exp_ok1));

    // Clear coincident with an accept: the accept is not counted.
    send(good_hdr(16'd5005, 16'd30));
    stat_clr = 1'b1;
    @(posedge clk);
    #1 stat_clr = 1'b0;
    exp_ok1 = '0; exp_drop1 = '0; exp_ok2 = '0; exp_drop2 = '0;
    @(negedge clk);
    check("clr_stat_ok", 128'(stat_ok), 128'(0));
    check("clr_stat_drop", 128'(stat_drop), 128'(0));
    check("clr_stat_ok2", 128'(stat_ok2), 128'(0));
    wait_idle();

    // Saturation of the narrow counters.
    for (int i = 0; i < 5; i++) send(good_hdr(16'd5006, 16'd50));
    for (int i = 0; i < 5; i++) send(good_hdr(16'd999, 16'd50));
    wait_idle();
    check("sat_stat_ok2", 128'(stat_ok2), 128'(exp_ok2));
    check("sat_stat_drop2", 128'(stat_drop2), 128'(exp_drop2));
    check("sat_stat_ok", 128'(stat_ok), 128'(exp_ok1));
    check("sat_stat_drop", 128'(stat_drop), 128'(exp_drop1));

    // Reset with three queued and one in stage 1.
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(good_hdr(16'd5005, 16'(20 + i)));
    check("pre_rst_level", 128'(fifo_level), 128'(3));
    rst = 1'b1;
    #1;
    check("mid_rst_level", 128'(fifo_level), 128'(0));
    check("mid_rst_m_valid", 128'(m_valid), 128'(0));
    check("mid_rst_s_ready", 128'(s_ready), 128'(0));
    check("mid_rst_stat_ok", 128'(stat_ok), 128'(0));
    sb_q.delete();
    err_q.delete();
    exp_ok1 = '0; exp_drop1 = '0; exp_ok2 = '0; exp_drop2 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_ready = 1'b1;
    #1 check("post_rst_s_ready", 128'(s_ready), 128'(1));
    lat_test(good_hdr(16'd5008, 16'd64), "post_rst");
    wait_idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
